// File: rtl/digit_scan_controller.sv
// Multiplexed four-digit display scanner: walks the digit selector from 11 down to 00, driving one active-low anode per period.
// Optional inter-digit ghost blanking is compiled in with `define SCAN_GHOST_BLANK_EN.
module digit_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic [3:0] blankMask,
    output logic [1:0] selector,
    output logic [3:0] anodeN,
    output logic       digitTick
);

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("digit_scan_controller: REFRESH_DIV must be >= 2 and BLANK_CYCLES >= 1");
    end

`ifdef SCAN_GHOST_BLANK_EN
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
`else
    typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         selector_d;
    logic [3:0]         anode_d;
    logic               tick_d;
    logic [1:0]         next_sel;

    assign next_sel = selector - 2'd1;

    // Active-low one-hot anode for a digit, left dark when its mask bit is set.
    function automatic logic [3:0] anode_for(input logic [1:0] sel, input logic [3:0] mask);
        logic [3:0] a;
        a = 4'b1111;
        if (!mask[sel]) a[sel] = 1'b0;
        return a;
    endfunction

    // NOTE: every output is computed here and registered below; each variable gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        selector_d = selector;
        anode_d    = 4'b1111;
        tick_d     = 1'b0;
`ifdef SCAN_GHOST_BLANK_EN
        blank_cnt_d = blank_cnt_q;
`endif
        if (!enable) begin
            state_d = IDLE;
            presc_d = '0;
`ifdef SCAN_GHOST_BLANK_EN
            blank_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    presc_d = '0;
                    anode_d = anode_for(selector, blankMask);
                end
                SHOW: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
`ifdef SCAN_GHOST_BLANK_EN
                        state_d     = BLANK;
                        blank_cnt_d = '0;
`else
                        selector_d = next_sel;
                        tick_d     = 1'b1;
                        anode_d    = anode_for(next_sel, blankMask);
`endif
                    end else begin
                        presc_d = presc_q + 1'b1;
                        anode_d = anode_for(selector, blankMask);
                    end
                end
`ifdef SCAN_GHOST_BLANK_EN
                // Selector only moves here, with all anodes already dark.
                BLANK: begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_d     = SHOW;
                        blank_cnt_d = '0;
                        selector_d  = next_sel;
                        tick_d      = 1'b1;
                        anode_d     = anode_for(next_sel, blankMask);
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            selector  <= 2'b11;
            anodeN    <= 4'b1111;
            digitTick <= 1'b0;
`ifdef SCAN_GHOST_BLANK_EN
            blank_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            selector  <= selector_d;
            anodeN    <= anode_d;
            digitTick <= tick_d;
`ifdef SCAN_GHOST_BLANK_EN
            blank_cnt_q <= blank_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_digit_scan_controller.sv
// Directed bench for digit_scan_controller at REFRESH_DIV=4, BLANK_CYCLES=2; expectations follow SCAN_GHOST_BLANK_EN.
module tb_digit_scan_controller;

    localparam int DIV = 4;
`ifdef SCAN_GHOST_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif
    localparam int PERIOD = DIV + BL;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] blankMask = 4'b0000;
    logic [1:0] selector;
    logic [3:0] anodeN;
    logic       digitTick;

    int tests = 0;
    int fails = 0;

    digit_scan_controller #(.REFRESH_DIV(DIV), .BLANK_CYCLES(2)) dut (
        .clk(clk), .resetN(resetN), .enable(enable), .blankMask(blankMask),
        .selector(selector), .anodeN(anodeN), .digitTick(digitTick)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_anode(input logic [1:0] s, input logic [3:0] m);
        logic [3:0] a;
        a = 4'b1111;
        if (!m[s]) a[s] = 1'b0;
        return a;
    endfunction

    function automatic logic [1:0] exp_sel(input int c);
        return 2'(3 - (((c - 1) / PERIOD) % 4));
    endfunction

    function automatic logic [3:0] exp_an(input int c, input logic [3:0] m);
        return (((c - 1) % PERIOD) < DIV) ? exp_anode(exp_sel(c), m) : 4'b1111;
    endfunction

    function automatic logic exp_tick(input int c);
        return (((c - 1) % PERIOD) == 0) && (c > 1);
    endfunction

    // Holds reset for two cycles, releases it on a falling edge; cycle 1 is the next falling edge.
    task automatic do_reset(input logic [3:0] m, input logic en);
        @(negedge clk);
        resetN = 1'b0;
        enable = en;
        blankMask = m;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_reset;
        logic [1:0] prev_sel;
        logic [3:0] prev_an;
        int ticks;
        @(negedge clk);
        resetN = 1'b0;
        enable = 1'b1;
        blankMask = 4'b0000;
        repeat (2) @(negedge clk);
        tests++;
        if ({selector, anodeN, digitTick} !== {2'b11, 4'b1111, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got sel=%b an=%b tick=%b, expected sel=11 an=1111 tick=0",
                     selector, anodeN, digitTick);
        end
        resetN = 1'b1;
        prev_sel = 2'b11;
        prev_an = 4'b1111;
        ticks = 0;
        for (int c = 1; c <= 4 * PERIOD + 1; c++) begin
            @(negedge clk);
            tests++;
            if ({selector, anodeN, digitTick} !== {exp_sel(c), exp_an(c, 4'b0000), exp_tick(c)}) begin
                fails++;
                $display("FAIL scan c=%0d: got sel=%b an=%b tick=%b, expected sel=%b an=%b tick=%b",
                         c, selector, anodeN, digitTick, exp_sel(c), exp_an(c, 4'b0000), exp_tick(c));
            end
`ifdef SCAN_GHOST_BLANK_EN
            tests++;
            if (selector !== prev_sel && prev_an !== 4'b1111) begin
                fails++;
                $display("FAIL ghost c=%0d: selector moved %b->%b while anode was %b, expected anode 1111",
                         c, prev_sel, selector, prev_an);
            end
`endif
            if (digitTick) ticks++;
            prev_sel = selector;
            prev_an = anodeN;
        end
        tests++;
        if (ticks != 4) begin
            fails++;
            $display("FAIL scan_ticks: got %0d, expected 4", ticks);
        end
    endtask

    task automatic test_mask;
        int ticks;
        do_reset(4'b0100, 1'b1);
        ticks = 0;
        for (int c = 1; c <= 4 * PERIOD + 1; c++) begin
            @(negedge clk);
            tests++;
            if ({selector, anodeN, digitTick} !== {exp_sel(c), exp_an(c, 4'b0100), exp_tick(c)}) begin
                fails++;
                $display("FAIL mask c=%0d: got sel=%b an=%b tick=%b, expected sel=%b an=%b tick=%b",
                         c, selector, anodeN, digitTick, exp_sel(c), exp_an(c, 4'b0100), exp_tick(c));
            end
            if (digitTick) ticks++;
        end
        tests++;
        if (ticks != 4) begin
            fails++;
            $display("FAIL mask_ticks: got %0d, expected 4", ticks);
        end
    endtask

    task automatic test_all_mask;
        int ticks;
        do_reset(4'b1111, 1'b1);
        ticks = 0;
        for (int c = 1; c <= 4 * PERIOD + 1; c++) begin
            @(negedge clk);
            tests++;
            if ({selector, anodeN, digitTick} !== {exp_sel(c), 4'b1111, exp_tick(c)}) begin
                fails++;
                $display("FAIL all_mask c=%0d: got sel=%b an=%b tick=%b, expected sel=%b an=1111 tick=%b",
                         c, selector, anodeN, digitTick, exp_sel(c), exp_tick(c));
            end
            if (digitTick) ticks++;
        end
        tests++;
        if (ticks != 4) begin
            fails++;
            $display("FAIL all_mask_ticks: got %0d, expected 4", ticks);
        end
    endtask

    task automatic test_mask_change;
        do_reset(4'b0000, 1'b1);
        repeat (2) @(negedge clk);
        blankMask = 4'b1000;
        @(negedge clk);
        tests++;
        if ({selector, anodeN, digitTick} !== {2'b11, 4'b1111, 1'b0}) begin
            fails++;
            $display("FAIL mask_on: got sel=%b an=%b tick=%b, expected sel=11 an=1111 tick=0",
                     selector, anodeN, digitTick);
        end
        blankMask = 4'b0000;
        @(negedge clk);
        tests++;
        if ({selector, anodeN, digitTick} !== {2'b11, 4'b0111, 1'b0}) begin
            fails++;
            $display("FAIL mask_off: got sel=%b an=%b tick=%b, expected sel=11 an=0111 tick=0",
                     selector, anodeN, digitTick);
        end
        repeat (PERIOD - 3) @(negedge clk);
        tests++;
        if ({selector, anodeN, digitTick} !== {2'b10, 4'b1011, 1'b1}) begin
            fails++;
            $display("FAIL mask_no_disturb: got sel=%b an=%b tick=%b, expected sel=10 an=1011 tick=1",
                     selector, anodeN, digitTick);
        end
    endtask

    task automatic test_enable_drop;
        logic [1:0] es;
        logic [3:0] ea;
        logic       et;
        do_reset(4'b0000, 1'b1);
        repeat (2 * PERIOD + 2) @(negedge clk);
        tests++;
        if ({selector, anodeN} !== {2'b01, 4'b1101}) begin
            fails++;
            $display("FAIL drop_setup: got sel=%b an=%b, expected sel=01 an=1101", selector, anodeN);
        end
        enable = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tests++;
            if ({selector, anodeN, digitTick} !== {2'b01, 4'b1111, 1'b0}) begin
                fails++;
                $display("FAIL drop_idle k=%0d: got sel=%b an=%b tick=%b, expected sel=01 an=1111 tick=0",
                         k, selector, anodeN, digitTick);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= PERIOD + 1; k++) begin
            @(negedge clk);
            if (k <= DIV) begin
                es = 2'b01; ea = 4'b1101; et = 1'b0;
            end else if (k <= PERIOD) begin
                es = 2'b01; ea = 4'b1111; et = 1'b0;
            end else begin
                es = 2'b00; ea = 4'b1110; et = 1'b1;
            end
            tests++;
            if ({selector, anodeN, digitTick} !== {es, ea, et}) begin
                fails++;
                $display("FAIL drop_resume k=%0d: got sel=%b an=%b tick=%b, expected sel=%b an=%b tick=%b",
                         k, selector, anodeN, digitTick, es, ea, et);
            end
        end
    endtask

    task automatic test_async_reset;
        int target;
        do_reset(4'b0000, 1'b1);
        // Macro build lands mid-BLANK of digit 10; otherwise mid-SHOW of digit 10.
        target = PERIOD + ((PERIOD > DIV) ? 5 : 2);
        repeat (target) @(negedge clk);
        tests++;
        if ({selector, anodeN} !== {exp_sel(target), exp_an(target, 4'b0000)}) begin
            fails++;
            $display("FAIL areset_setup: got sel=%b an=%b, expected sel=%b an=%b",
                     selector, anodeN, exp_sel(target), exp_an(target, 4'b0000));
        end
        #2 resetN = 1'b0;
        #1;
        tests++;
        if ({selector, anodeN, digitTick} !== {2'b11, 4'b1111, 1'b0}) begin
            fails++;
            $display("FAIL areset_immediate: got sel=%b an=%b tick=%b, expected sel=11 an=1111 tick=0",
                     selector, anodeN, digitTick);
        end
        @(negedge clk);
        resetN = 1'b1;
        for (int c = 1; c <= PERIOD + 1; c++) begin
            @(negedge clk);
            tests++;
            if ({selector, anodeN, digitTick} !== {exp_sel(c), exp_an(c, 4'b0000), exp_tick(c)}) begin
                fails++;
                $display("FAIL areset_restart c=%0d: got sel=%b an=%b tick=%b, expected sel=%b an=%b tick=%b",
                         c, selector, anodeN, digitTick, exp_sel(c), exp_an(c, 4'b0000), exp_tick(c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mask();
        test_all_mask();
        test_mask_change();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
